display_scanner: RTL and testbench

//  Time-multiplexes up to N_DIGITS BCD digits onto one shared 7-segment cathode bus.

---
 rtl/display_scanner_if.sv | 24 ++
 rtl/display_scanner.sv | 69 ++++++
 tb/tb_display_scanner.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/display_scanner_if.sv
// rtl/display_scanner_if.sv - digit data in, scanned 7-segment drive out
interface display_scanner_if #(
  parameter int N_DIGITS = 8,
  parameter int IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
);
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   digit_en;
  logic [N_DIGITS-1:0]   blink_mask;
  logic [N_DIGITS-1:0]   dp_mask;
  logic [3:0]            bcd;
  logic [N_DIGITS-1:0]   anodes;
  logic                  dp;
  logic [IW-1:0]         digit_idx;

  modport master (
    output digits, digit_en, blink_mask, dp_mask,
    input  bcd, anodes, dp, digit_idx
  );

  modport slave (
    input  digits, digit_en, blink_mask, dp_mask,
    output bcd, anodes, dp, digit_idx
  );
endinterface

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - time-multiplexed 7-segment digit scanner
// with per-digit enable, blink and decimal-point masks.
module display_scanner #(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_DIV    = 25000000
) (
  input logic          clk,
  input logic          reset,
  display_scanner_if.slave bus
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0]       presc_last = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]       blank_end  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0]       idx_last   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0]       bcnt_last  = BW'(BLINK_DIV - 1);
  localparam logic [N_DIGITS-1:0] one_hot0   = N_DIGITS'(1);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;
  logic          blink_off;
  logic          show;
  logic [3:0]    cur_bcd;

  // The first BLANK_CYCLES of each slot stay dark so the previous digit's
  // cathode pattern never ghosts onto the newly selected anode.
  always_comb begin
    show    = bus.digit_en[idx] & ~(bus.blink_mask[idx] & blink_off)
              & (presc >= blank_end);
    cur_bcd = bus.digits[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc         <= '0;
      idx           <= '0;
      bcnt          <= '0;
      blink_off     <= 1'b0;
      bus.bcd       <= 4'hF;
      bus.anodes    <= '1;
      bus.dp        <= 1'b1;
      bus.digit_idx <= '0;
    end else begin
      if (presc == presc_last) begin
        presc <= '0;
        idx   <= (idx == idx_last) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (bcnt == bcnt_last) begin
        bcnt      <= '0;
        blink_off <= ~blink_off;
      end else begin
        bcnt <= bcnt + 1'b1;
      end

      bus.bcd       <= cur_bcd;
      bus.digit_idx <= idx;
      bus.anodes    <= show ? ~(one_hot0 << idx) : '1;
      bus.dp        <= ~(show & bus.dp_mask[idx]);
    end
  end
endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - table-driven check of display_scanner (4 digits, fast dividers)
module tb_display_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  display_scanner_if #(.N_DIGITS(4)) bus ();

  display_scanner #(
    .N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_DIV(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  en;
    logic [3:0]  blink;
    logic [3:0]  dpm;
    int          e;      // posedges after reset release before sampling
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic        dp;
    logic [1:0]  idx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [15:0] d, logic [3:0] en, logic [3:0] bl,
                              logic [3:0] dpm, int e, logic [3:0] an,
                              logic [3:0] bcd, logic dp, logic [1:0] idx);
    vec_t v;
    v.digits = d; v.en = en; v.blink = bl; v.dpm = dpm; v.e = e;
    v.an = an; v.bcd = bcd; v.dp = dp; v.idx = idx;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [15:0] d, logic [3:0] en, logic [3:0] bl, logic [3:0] dpm);
    bus.digits = d; bus.digit_en = en; bus.blink_mask = bl; bus.dp_mask = dpm;
  endtask

  // Reset is applied over two posedges and released on a negedge, so the
  // next posedge is edge 1 after release.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  int cnt_e, cnt_d, cnt_b, cnt_7, cnt_other, lit, bad_an, seen_idx;

  initial begin
    vecs.push_back(mk(16'h4321, 4'hF, 4'h0, 4'h0,   1, 4'hF, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h0, 4'h0,   3, 4'hE, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h0, 4'h0,   8, 4'hE, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h0, 4'h0,   9, 4'hF, 4'h2, 1'b1, 2'd1));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h0, 4'h0,  11, 4'hD, 4'h2, 1'b1, 2'd1));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h0, 4'h4,  19, 4'hB, 4'h3, 1'b0, 2'd2));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h0, 4'h4,  17, 4'hF, 4'h3, 1'b1, 2'd2));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h0, 4'h4,  27, 4'h7, 4'h4, 1'b1, 2'd3));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h0, 4'h0,  35, 4'hE, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h1, 4'h0,   3, 4'hE, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h1, 4'h0,  67, 4'hF, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h1, 4'h0,  75, 4'hD, 4'h2, 1'b1, 2'd1));
    vecs.push_back(mk(16'h4321, 4'hF, 4'h1, 4'h0, 131, 4'hE, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(16'h4321, 4'hA, 4'h0, 4'h0,   3, 4'hF, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(16'h4321, 4'hA, 4'h0, 4'h0,  11, 4'hD, 4'h2, 1'b1, 2'd1));
    vecs.push_back(mk(16'h4321, 4'h0, 4'h0, 4'hF,  11, 4'hF, 4'h2, 1'b1, 2'd1));
    vecs.push_back(mk(16'hFA09, 4'hF, 4'h0, 4'h0,  19, 4'hB, 4'hA, 1'b1, 2'd2));
    vecs.push_back(mk(16'hFA09, 4'hF, 4'h0, 4'h0,  27, 4'h7, 4'hF, 1'b1, 2'd3));
    vecs.push_back(mk(16'hFA09, 4'hF, 4'h0, 4'h1,   3, 4'hE, 4'h9, 1'b0, 2'd0));

    drive(16'h4321, 4'hF, 4'h0, 4'h0);

    // Outputs while reset is held
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_anodes", 32'(bus.anodes), 32'hF);
    check("reset_dp", 32'(bus.dp), 32'h1);
    check("reset_bcd", 32'(bus.bcd), 32'hF);
    check("reset_idx", 32'(bus.digit_idx), 32'h0);
    reset = 1'b0;

    // Latency to the first lit anode
    cnt_e = 0;
    while (bus.anodes === 4'hF && cnt_e < 20) begin
      step(1);
      cnt_e++;
    end
    check("first_lit_latency", 32'(cnt_e), 32'd3);
    check("first_lit_anodes", 32'(bus.anodes), 32'hE);

    foreach (vecs[i]) begin
      drive(vecs[i].digits, vecs[i].en, vecs[i].blink, vecs[i].dpm);
      do_reset();
      step(vecs[i].e);
      check($sformatf("vec%0d_anodes", i), 32'(bus.anodes), 32'(vecs[i].an));
      check($sformatf("vec%0d_bcd", i), 32'(bus.bcd), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_dp", i), 32'(bus.dp), 32'(vecs[i].dp));
      check($sformatf("vec%0d_idx", i), 32'(bus.digit_idx), 32'(vecs[i].idx));
    end

    // Full scan: each digit low for 6 of its 8 cycles
    drive(16'h4321, 4'hF, 4'h0, 4'h0);
    do_reset();
    cnt_e = 0; cnt_d = 0; cnt_b = 0; cnt_7 = 0; cnt_other = 0;
    for (int k = 0; k < 32; k++) begin
      step(1);
      case (bus.anodes)
        4'hE: cnt_e++;
        4'hD: cnt_d++;
        4'hB: cnt_b++;
        4'h7: cnt_7++;
        4'hF: ;
        default: cnt_other++;
      endcase
    end
    check("scan_cnt_d0", 32'(cnt_e), 32'd6);
    check("scan_cnt_d1", 32'(cnt_d), 32'd6);
    check("scan_cnt_d2", 32'(cnt_b), 32'd6);
    check("scan_cnt_d3", 32'(cnt_7), 32'd6);
    check("scan_bad_pattern", 32'(cnt_other), 32'd0);

    // Blink: digit 0 lit in the first 64-cycle phase, dark in the second
    drive(16'h4321, 4'hF, 4'h1, 4'h0);
    do_reset();
    lit = 0; cnt_d = 0;
    for (int k = 0; k < 64; k++) begin
      step(1);
      if (bus.anodes === 4'hE) lit++;
    end
    check("blink_on_lit", 32'(lit), 32'd12);
    lit = 0;
    for (int k = 0; k < 64; k++) begin
      step(1);
      if (bus.anodes === 4'hE) lit++;
      if (bus.anodes === 4'hD) cnt_d++;
    end
    check("blink_off_lit", 32'(lit), 32'd0);
    check("blink_other_digit", 32'(cnt_d), 32'd12);

    // Sparse enable: only digits 1 and 3 light, scan index still cycles
    drive(16'h4321, 4'hA, 4'h0, 4'h0);
    do_reset();
    cnt_other = 0; seen_idx = 0;
    for (int k = 0; k < 64; k++) begin
      step(1);
      if (!(bus.anodes inside {4'hF, 4'hD, 4'h7})) cnt_other++;
      seen_idx |= (1 << bus.digit_idx);
      if (bus.bcd !== 4'(bus.digit_idx + 1)) cnt_other++;
    end
    check("en_sparse_bad", 32'(cnt_other), 32'd0);
    check("en_sparse_idx_seen", 32'(seen_idx), 32'hF);

    // Reset mid-slot at idx=2, presc=5, then scan restarts with full blank
    drive(16'h4321, 4'hF, 4'h0, 4'h0);
    do_reset();
    step(21);
    check("pre_abort_anodes", 32'(bus.anodes), 32'hB);
    reset = 1'b1;
    step(1);
    check("abort_anodes", 32'(bus.anodes), 32'hF);
    check("abort_idx", 32'(bus.digit_idx), 32'd0);
    reset = 1'b0;
    bad_an = 0; cnt_e = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if ($countones(~bus.anodes) > 1) bad_an++;
      if (k <= 2 && bus.anodes !== 4'hF) bad_an++;
      if (k >= 3 && k <= 8 && bus.anodes === 4'hE) cnt_e++;
    end
    check("restart_glitch", 32'(bad_an), 32'd0);
    check("restart_d0_lit", 32'(cnt_e), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
